// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator: scan-based polyphonic voice scheduler (retrigger, free-slot, oldest-steal).
// Optional feature macro VOICE_STEAL_EN: when all voices sound, a note_on steals the oldest voice.
module midi_voice_allocator #(
   parameter int NUM_VOICES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              note_in,
   input  logic                    note_on,
   input  logic                    note_off,
   output logic                    ready,
   output logic [8*NUM_VOICES-1:0] voice_note,
   output logic [NUM_VOICES-1:0]   voice_active,
   output logic [7:0]              mono_note,
   output logic                    stole,
   output logic                    dropped
);
   localparam int IW = $clog2(NUM_VOICES);
   localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
   state_t state, state_nxt;

   logic [IW-1:0] idx;
   logic [7:0]    ev_note;
   logic          ev_off;
   logic          hit_found, free_found;
   logic [IW-1:0] hit_idx, free_idx;
`ifdef VOICE_STEAL_EN
   logic          old_found;
   logic [IW-1:0] old_idx, old_age;
   logic          stole_r;
`endif

   logic [7:0]            notes     [NUM_VOICES];
   logic [IW-1:0]         ages      [NUM_VOICES];
   logic [NUM_VOICES-1:0] active;
   logic [7:0]            notes_nxt [NUM_VOICES];
   logic [IW-1:0]         ages_nxt  [NUM_VOICES];
   logic [NUM_VOICES-1:0] active_nxt;
   logic [7:0]            mono_r, mono_nxt;
   logic                  mono_found;
   logic [IW-1:0]         mono_age;
   logic                  steal_nxt, full_drop, dropped_r;

   logic event_in, accept, reject;
   assign event_in = note_on | note_off;
   assign accept   = (state == IDLE) && event_in && !note_in[7];
   assign reject   = event_in && !accept;

   function automatic logic [IW-1:0] age_inc(input logic [IW-1:0] a);
      return (a == LAST) ? a : a + IW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SCAN;
         SCAN:    if (idx == LAST) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Commit decision: next voice table computed from the scan results.
   always_comb begin
      notes_nxt  = notes;
      ages_nxt   = ages;
      active_nxt = active;
      steal_nxt  = 1'b0;
      full_drop  = 1'b0;
      if (state == COMMIT) begin
         if (ev_off) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
               if (active[v] && notes[v] == ev_note) begin
                  active_nxt[v] = 1'b0;
                  notes_nxt[v]  = 8'd0;
                  ages_nxt[v]   = '0;
               end
            end
         end else if (hit_found) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
               if (IW'(v) == hit_idx)
                  ages_nxt[v] = '0;
               else if (active[v] && ages[v] < ages[hit_idx])
                  ages_nxt[v] = age_inc(ages[v]);
            end
         end else if (free_found) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
               if (IW'(v) == free_idx) begin
                  notes_nxt[v]  = ev_note;
                  active_nxt[v] = 1'b1;
                  ages_nxt[v]   = '0;
               end else if (active[v]) begin
                  ages_nxt[v] = age_inc(ages[v]);
               end
            end
         end else begin
`ifdef VOICE_STEAL_EN
            steal_nxt = old_found;
            for (int v = 0; v < NUM_VOICES; v++) begin
               if (IW'(v) == old_idx) begin
                  notes_nxt[v] = ev_note;
                  ages_nxt[v]  = '0;
               end else begin
                  ages_nxt[v] = age_inc(ages[v]);
               end
            end
`else
            full_drop = 1'b1;
`endif
         end
      end
   end

   // Most recently allocated voice is the active one with the smallest age.
   always_comb begin
      mono_nxt   = 8'd0;
      mono_found = 1'b0;
      mono_age   = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (active_nxt[v] && (!mono_found || ages_nxt[v] < mono_age)) begin
            mono_found = 1'b1;
            mono_age   = ages_nxt[v];
            mono_nxt   = notes_nxt[v];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx        <= '0;
         ev_note    <= 8'd0;
         ev_off     <= 1'b0;
         hit_found  <= 1'b0;
         free_found <= 1'b0;
         hit_idx    <= '0;
         free_idx   <= '0;
`ifdef VOICE_STEAL_EN
         old_found  <= 1'b0;
         old_idx    <= '0;
         old_age    <= '0;
         stole_r    <= 1'b0;
`endif
         for (int v = 0; v < NUM_VOICES; v++) begin
            notes[v] <= 8'd0;
            ages[v]  <= '0;
         end
         active    <= '0;
         mono_r    <= 8'd0;
         dropped_r <= 1'b0;
      end else begin
         dropped_r <= reject | full_drop;
`ifdef VOICE_STEAL_EN
         stole_r   <= steal_nxt;
`endif
         case (state)
            IDLE: begin
               if (accept) begin
                  ev_note    <= note_in;
                  ev_off     <= note_off;
                  idx        <= '0;
                  hit_found  <= 1'b0;
                  free_found <= 1'b0;
`ifdef VOICE_STEAL_EN
                  old_found  <= 1'b0;
`endif
               end
            end
            SCAN: begin
               idx <= idx + IW'(1);
               if (active[idx] && notes[idx] == ev_note && !hit_found) begin
                  hit_found <= 1'b1;
                  hit_idx   <= idx;
               end
               if (!active[idx] && !free_found) begin
                  free_found <= 1'b1;
                  free_idx   <= idx;
               end
`ifdef VOICE_STEAL_EN
               if (active[idx] && (!old_found || ages[idx] > old_age)) begin
                  old_found <= 1'b1;
                  old_idx   <= idx;
                  old_age   <= ages[idx];
               end
`endif
            end
            COMMIT: begin
               for (int v = 0; v < NUM_VOICES; v++) begin
                  notes[v] <= notes_nxt[v];
                  ages[v]  <= ages_nxt[v];
               end
               active <= active_nxt;
               mono_r <= mono_nxt;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      voice_note = '0;
      for (int v = 0; v < NUM_VOICES; v++) voice_note[8*v +: 8] = notes[v];
   end

   assign ready        = (state == IDLE);
   assign voice_active = active;
   assign mono_note    = mono_r;
   assign dropped      = dropped_r;
`ifdef VOICE_STEAL_EN
   assign stole        = stole_r;
`else
   assign stole        = 1'b0;
`endif

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: event-level voice model plus per-cycle output comparison.
module tb_midi_voice_allocator;
   localparam int NV = 4;

   logic            clk, reset;
   logic [7:0]      note_in;
   logic            note_on, note_off;
   logic            ready;
   logic [8*NV-1:0] voice_note;
   logic [NV-1:0]   voice_active;
   logic [7:0]      mono_note;
   logic            stole, dropped;

   midi_voice_allocator #(.NUM_VOICES(NV)) dut (
      .clk(clk), .reset(reset), .note_in(note_in), .note_on(note_on), .note_off(note_off),
      .ready(ready), .voice_note(voice_note), .voice_active(voice_active),
      .mono_note(mono_note), .stole(stole), .dropped(dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;
   int stole_cnt = 0;
   int drop_cnt = 0;

   // Model: voice table as the specification describes it, updated when an event completes.
   int   m_note [NV];
   bit   m_act  [NV];
   int   m_age  [NV];
   int   cnt = 0;
   int   p_note;
   bit   p_off;
   bit   exp_ready = 1, exp_stole = 0, exp_drop = 0;
   int   exp_mono = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int a);
      return (a > NV - 1) ? NV - 1 : a;
   endfunction

   task automatic apply_event();
      int hit, free, old, ha, best;
      hit = -1; free = -1; old = -1;
      if (p_off) begin
         for (int v = 0; v < NV; v++)
            if (m_act[v] && m_note[v] == p_note) begin
               m_act[v] = 0; m_note[v] = 0; m_age[v] = 0;
            end
      end else begin
         for (int v = 0; v < NV; v++) begin
            if (m_act[v] && m_note[v] == p_note && hit < 0) hit = v;
            if (!m_act[v] && free < 0) free = v;
            if (m_act[v] && (old < 0 || m_age[v] > m_age[old])) old = v;
         end
         if (hit >= 0) begin
            ha = m_age[hit];
            for (int v = 0; v < NV; v++)
               if (v != hit && m_act[v] && m_age[v] < ha) m_age[v] = sat(m_age[v] + 1);
            m_age[hit] = 0;
         end else if (free >= 0) begin
            for (int v = 0; v < NV; v++)
               if (m_act[v]) m_age[v] = sat(m_age[v] + 1);
            m_note[free] = p_note; m_act[free] = 1; m_age[free] = 0;
         end else begin
`ifdef VOICE_STEAL_EN
            for (int v = 0; v < NV; v++)
               if (v != old) m_age[v] = sat(m_age[v] + 1);
            m_note[old] = p_note; m_age[old] = 0; exp_stole = 1;
`else
            exp_drop = 1;
`endif
         end
      end
      exp_mono = 0; best = NV + 1;
      for (int v = 0; v < NV; v++)
         if (m_act[v] && m_age[v] < best) begin best = m_age[v]; exp_mono = m_note[v]; end
   endtask

   always @(posedge clk) begin
      bit rdy_b, ev;
      exp_stole = 0;
      exp_drop  = 0;
      if (reset) begin
         for (int v = 0; v < NV; v++) begin m_note[v] = 0; m_act[v] = 0; m_age[v] = 0; end
         cnt = 0; exp_mono = 0;
      end else begin
         rdy_b = (cnt == 0);
         ev = note_on | note_off;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) apply_event();
         end
         if (ev) begin
            if (rdy_b && !note_in[7]) begin
               p_note = int'(note_in); p_off = note_off; cnt = NV + 1;
            end else exp_drop = 1;
         end
      end
      exp_ready = (cnt == 0);
   end

   function automatic logic [8*NV-1:0] exp_notes();
      logic [8*NV-1:0] r;
      for (int v = 0; v < NV; v++) r[8*v +: 8] = 8'(m_note[v]);
      return r;
   endfunction

   function automatic logic [NV-1:0] exp_act();
      logic [NV-1:0] r;
      for (int v = 0; v < NV; v++) r[v] = m_act[v];
      return r;
   endfunction

   always @(negedge clk) begin
      if (stole)   stole_cnt++;
      if (dropped) drop_cnt++;
      if (cmp_en) begin
         chk("ready",        ready,        exp_ready);
         chk("voice_active", voice_active, exp_act());
         chk("voice_note",   voice_note,   exp_notes());
         chk("mono_note",    mono_note,    8'(exp_mono));
         chk("stole",        stole,        exp_stole);
         chk("dropped",      dropped,      exp_drop);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit on, input bit off, input logic [7:0] n);
      note_on = on; note_off = off; note_in = n;
      tick();
      note_on = 0; note_off = 0; note_in = 8'd0;
   endtask

   task automatic wait_ready(output int lat);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ready === 1'b1) break;
         lat++;
      end
   endtask

   task automatic do_evt(input bit on, input bit off, input logic [7:0] n, input int exp_lat);
      int lat;
      send(on, off, n);
      wait_ready(lat);
      chk("latency", lat, exp_lat);
      tick();
   endtask

   task automatic do_reset();
      reset = 1;
      tick(); tick();
      reset = 0;
      stole_cnt = 0; drop_cnt = 0;
   endtask

   initial begin
      int lat;
      reset = 1; note_on = 0; note_off = 0; note_in = 8'd0;
      tick();
      cmp_en = 1;
      tick();
      chk("rst_ready",  ready,        1'b1);
      chk("rst_active", voice_active, 4'b0000);
      chk("rst_notes",  voice_note,   32'h0);
      chk("rst_mono",   mono_note,    8'd0);
      reset = 0;

      // First allocation and its latency
      do_evt(1, 0, 8'd60, NV + 1);
      chk("first_active", voice_active, 4'b0001);
      chk("first_note",   voice_note[7:0], 8'd60);
      chk("first_mono",   mono_note, 8'd60);
      chk("first_ready",  ready, 1'b1);

      // Fill all voices, then one more note_on
      do_evt(1, 0, 8'd64, NV + 1);
      do_evt(1, 0, 8'd67, NV + 1);
      do_evt(1, 0, 8'd72, NV + 1);
      chk("full_mono", mono_note, 8'd72);
      stole_cnt = 0; drop_cnt = 0;
      do_evt(1, 0, 8'd76, NV + 1);
      chk("full_active", voice_active, 4'b1111);
`ifdef VOICE_STEAL_EN
      chk("steal_notes", voice_note, {8'd72, 8'd67, 8'd64, 8'd76});
      chk("steal_mono",  mono_note, 8'd76);
      chk("steal_cnt",   stole_cnt, 1);
      chk("steal_drops", drop_cnt, 0);
`else
      chk("nosteal_notes", voice_note, {8'd72, 8'd67, 8'd64, 8'd60});
      chk("nosteal_mono",  mono_note, 8'd72);
      chk("nosteal_cnt",   stole_cnt, 0);
      chk("nosteal_drops", drop_cnt, 1);
`endif

      // Release and reuse
      do_reset();
      do_evt(1, 0, 8'd60, NV + 1);
      do_evt(1, 0, 8'd64, NV + 1);
      do_evt(0, 1, 8'd60, NV + 1);
      chk("rel_active", voice_active, 4'b0010);
      chk("rel_notes",  voice_note, {8'd0, 8'd0, 8'd64, 8'd0});
      chk("rel_mono",   mono_note, 8'd64);
      do_evt(1, 0, 8'd62, NV + 1);
      chk("reuse_notes", voice_note, {8'd0, 8'd0, 8'd64, 8'd62});
      chk("reuse_mono",  mono_note, 8'd62);

      // Retrigger of a note already in voice 2
      do_reset();
      do_evt(1, 0, 8'd50, NV + 1);
      do_evt(1, 0, 8'd55, NV + 1);
      do_evt(1, 0, 8'd60, NV + 1);
      do_evt(1, 0, 8'd64, NV + 1);
      stole_cnt = 0;
      do_evt(1, 0, 8'd60, NV + 1);
      chk("hit_notes",  voice_note, {8'd64, 8'd60, 8'd55, 8'd50});
      chk("hit_mono",   mono_note, 8'd60);
      chk("hit_stole",  stole_cnt, 0);
      do_evt(0, 1, 8'd64, NV + 1);
      chk("hit_rel_mono", mono_note, 8'd60);
      do_evt(1, 0, 8'd80, NV + 1);
      chk("hit_refill", voice_note, {8'd80, 8'd60, 8'd55, 8'd50});
      do_evt(1, 0, 8'd70, NV + 1);
`ifdef VOICE_STEAL_EN
      chk("tie_steal", voice_note, {8'd80, 8'd60, 8'd55, 8'd70});
      chk("tie_mono",  mono_note, 8'd70);
`else
      chk("tie_keep",  voice_note, {8'd80, 8'd60, 8'd55, 8'd50});
      chk("tie_mono",  mono_note, 8'd80);
`endif

      // Event while busy is discarded
      do_reset();
      note_on = 1; note_in = 8'd30;
      tick();
      note_in = 8'd31;
      tick();
      note_on = 0; note_in = 8'd0;
      wait_ready(lat);
      chk("busy_latency", lat, NV);
      tick();
      chk("busy_drops",  drop_cnt, 1);
      chk("busy_notes",  voice_note, {8'd0, 8'd0, 8'd0, 8'd30});
      chk("busy_active", voice_active, 4'b0001);

      // Note numbers with bit 7 set are ignored
      drop_cnt = 0;
      do_evt(1, 0, 8'h80, 0);
      chk("hi_drops",  drop_cnt, 1);
      chk("hi_active", voice_active, 4'b0001);

      // Both strobes act as note_off
      do_reset();
      do_evt(1, 0, 8'd60, NV + 1);
      do_evt(1, 1, 8'd60, NV + 1);
      chk("both_active", voice_active, 4'b0000);
      chk("both_mono",   mono_note, 8'd0);
      chk("both_notes",  voice_note, 32'h0);

      // Reset in the middle of a scan
      do_evt(1, 0, 8'd40, NV + 1);
      send(1, 0, 8'd61);
      tick();
      reset = 1;
      tick();
      chk("mid_ready",  ready, 1'b1);
      chk("mid_active", voice_active, 4'b0000);
      chk("mid_notes",  voice_note, 32'h0);
      chk("mid_mono",   mono_note, 8'd0);
      reset = 0;
      for (int i = 0; i < NV + 3; i++) tick();
      chk("mid_lost", voice_active, 4'b0000);

      cmp_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1);
   end

endmodule
